pixel_serializer: RTL and testbench
===================================

Name: pixel_serializer

Overview:
- Consumer end of the parallel raster path. The coordinate generator drives POS_COUNT shader lanes per step.
- This block accepts one beat of POS_COUNT lane pixels at a time and emits them one pixel per transfer, in raster order.
- Each output pixel carries its reconstructed x, y and linear framebuffer address.
- It sits between the shader lanes and the framebuffer/SPI memory writer.

Parameters:
- WIDTH, 256, frame width in pixels; must be a multiple of POS_COUNT.
- HEIGHT, 256, frame height in pixels.
- POS_COUNT, 4, lanes per input beat; lane i holds the pixel at x = beat_base + i.
- PIXEL_BITS, 16, bits per pixel.
- Derived localparams: WIDTH_BITS = $clog2(WIDTH), HEIGHT_BITS = $clog2(HEIGHT), ADDR_BITS = $clog2(WIDTH*HEIGHT), LANE_BITS = $clog2(POS_COUNT) (minimum 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_pixel  in  [POS_COUNT][PIXEL_BITS]  lane pixels, unpacked array
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts pixel
- out_pixel  out  PIXEL_BITS  current pixel
- out_x  out  WIDTH_BITS  x of out_pixel
- out_y  out  HEIGHT_BITS  y of out_pixel
- out_addr  out  ADDR_BITS  y*WIDTH + x
- out_last  out  1  high with the final pixel of the frame (x=WIDTH-1, y=HEIGHT-1)
- frame_done  out  1  one-cycle pulse after the last pixel is transferred

Behaviour:
- Reset values:
  - Active buffer empty.
  - in_ready=1, out_valid=0, out_pixel=0, out_x=0, out_y=0, out_addr=0, out_last=0, frame_done=0.
  - Lane index = 0.
- Transfers:
  - An input beat is accepted when in_valid && in_ready.
  - An output pixel is transferred when out_valid && out_ready.
- Handshake rules:
  - out_valid stays high and out_* stay stable until transferred.
  - in_valid is never required to wait on in_ready.
- State machine, EMPTY / SHIFT:
  - EMPTY: in_ready=1, out_valid=0. Accepted beat → capture all lanes, lane index=0, go to SHIFT.
  - SHIFT: out_valid=1, out_pixel=lane[index].
    - Transfer with index<POS_COUNT-1 → index+1.
    - Transfer with index==POS_COUNT-1 → EMPTY.
- Latency and throughput:
  - Beat accepted on cycle N → lane 0 is valid on cycle N+1.
  - Without the optional feature, in_ready=0 in SHIFT, so peak throughput is POS_COUNT pixels per POS_COUNT+1 cycles.
- Coordinate counters advance only on an output transfer:
  - x+1 and addr+1 on every transfer.
  - At x==WIDTH-1: x→0 and y+1.
  - At x==WIDTH-1 and y==HEIGHT-1: x→0, y→0, addr→0.
- out_last is combinational from the current coordinates (x==WIDTH-1 && y==HEIGHT-1) and is qualified by out_valid.
- frame_done goes high for exactly one cycle on the cycle after an out_last transfer.
- Frames are back-to-back; the next beat starts at (0,0) with no re-arm.
- Comparisons are done at WIDTH_BITS/HEIGHT_BITS width against WIDTH-1 and HEIGHT-1. No modulo is used, so non-power-of-2 sizes are legal.
- out_ready low holds all state, with no loss or duplication.
- rst mid-frame discards any buffered beat and returns all coordinates to 0 on the next cycle.

Optional Feature:
- Macro: PIXEL_SERIALIZER_SKID_EN.
- When defined:
  - A second holding register is added and in_ready = !hold_full, so a beat can be accepted during SHIFT.
  - When the last lane transfers while the hold register is full, the hold register moves into the active buffer in the same cycle and index returns to 0.
  - This sustains 1 pixel/cycle with no bubble.
  - A beat accepted in the same cycle the hold register drains goes into the hold register.
  - A beat arriving while EMPTY loads the active buffer directly.
  - Reset clears both registers.
- When undefined: single buffer only; behaviour is exactly as above.

Decomposition:
- Package raster_pkg holds the WIDTH/HEIGHT/POS_COUNT defaults and a pixel_t typedef parameterised by PIXEL_BITS. The coordinate generator shares the package.
- The coordinate counter stays inline, since it is the mirror of the generator's update.
- One natural sub-module: lane_buffer. It is a POS_COUNT-wide capture register with full flag, load and clear, and is instantiated once, or twice under PIXEL_SERIALIZER_SKID_EN.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=2, POS_COUNT=4, PIXEL_BITS=8.
1. Reset, then one beat {10,11,12,13} with out_ready=1 → out_pixel 10,11,12,13 on cycles N+1..N+4; x 0..3; addr 0..3; in_ready low during those cycles (feature off).
2. Four beats with values 0x00..0x0F, out_ready=1 → addresses 0..15. At addr 7: x=7, y=0, next x=0, y=1. out_last only at addr 15. frame_done pulses the cycle after. The next beat's first pixel has addr 0.
3. out_ready toggled 1,0,0,1 pseudo-randomly over 2 frames → output sequence matches the input lane order exactly; out_* stable while stalled.
4. rst asserted mid-beat at lane 2 of frame position addr 6 → next cycle out_valid=0, in_ready=1; next beat starts at x=0, y=0, addr=0.
5. PIXEL_SERIALIZER_SKID_EN, in_valid=1 continuously, out_ready=1 → out_valid high every cycle for 16 cycles; addr 0..15 with no bubble.
6. PIXEL_SERIALIZER_SKID_EN, out_ready=0 after the 2nd beat is accepted → in_ready=0 with both buffers full; releasing out_ready yields 8 pixels in order.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster-path defaults and types, used by the coordinate generator and the pixel serializer.
package raster_pkg;

  localparam int DEFAULT_WIDTH      = 256;
  localparam int DEFAULT_HEIGHT     = 256;
  localparam int DEFAULT_POS_COUNT  = 4;
  localparam int DEFAULT_PIXEL_BITS = 16;

  typedef logic [DEFAULT_PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // $clog2 that never returns zero, so a 1-entry dimension still gets a 1-bit counter
  function automatic int clog2_min1(input int value);
    int bits;
    bits = $clog2(value);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/pixel_serializer_lane_buffer.sv
// lane_buffer: one captured input beat of POS_COUNT lane pixels plus its full flag.
module lane_buffer
  import raster_pkg::*;
#(
  parameter int POS_COUNT  = DEFAULT_POS_COUNT,
  parameter int PIXEL_BITS = DEFAULT_PIXEL_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [PIXEL_BITS-1:0] load_data [POS_COUNT],
  output logic [PIXEL_BITS-1:0] lanes     [POS_COUNT],
  output logic                  full
);

  // Load wins over clear so a buffer that drains can be refilled in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      for (int i = 0; i < POS_COUNT; i++) begin
        lanes[i] <= '0;
      end
    end else if (load) begin
      full <= 1'b1;
      for (int i = 0; i < POS_COUNT; i++) begin
        lanes[i] <= load_data[i];
      end
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// pixel_serializer: turns POS_COUNT-lane beats into a raster-ordered pixel stream with x/y/addr.
// Define PIXEL_SERIALIZER_SKID_EN to add a hold buffer that sustains one pixel per cycle.
module pixel_serializer
  import raster_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT,
  parameter int POS_COUNT  = DEFAULT_POS_COUNT,
  parameter int PIXEL_BITS = DEFAULT_PIXEL_BITS,
  localparam int WIDTH_BITS  = clog2_min1(WIDTH),
  localparam int HEIGHT_BITS = clog2_min1(HEIGHT),
  localparam int ADDR_BITS   = clog2_min1(WIDTH * HEIGHT),
  localparam int LANE_BITS   = clog2_min1(POS_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_BITS-1:0]  in_pixel [POS_COUNT],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_BITS-1:0]  out_pixel,
  output logic [WIDTH_BITS-1:0]  out_x,
  output logic [HEIGHT_BITS-1:0] out_y,
  output logic [ADDR_BITS-1:0]   out_addr,
  output logic                   out_last,
  output logic                   frame_done
);

  ser_state_t             state_r;
  logic [LANE_BITS-1:0]   index_r;
  logic [WIDTH_BITS-1:0]  x_r;
  logic [HEIGHT_BITS-1:0] y_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic                   out_valid_r;
  logic [PIXEL_BITS-1:0]  out_pixel_r;
  logic                   frame_done_r;

  logic                   accept_s;
  logic                   xfer_s;
  logic                   last_lane_s;
  logic                   drain_s;
  logic [LANE_BITS-1:0]   lane_next_s;
  logic                   x_wrap_s;
  logic                   y_wrap_s;
  logic                   refill_hold_s;
  logic                   refill_in_s;

  logic                   active_load_s;
  logic                   active_clear_s;
  logic                   active_full_s;
  logic [PIXEL_BITS-1:0]  active_load_data_s [POS_COUNT];
  logic [PIXEL_BITS-1:0]  active_data_s      [POS_COUNT];

`ifdef PIXEL_SERIALIZER_SKID_EN
  logic                   hold_load_s;
  logic                   hold_clear_s;
  logic                   hold_full_s;
  logic [PIXEL_BITS-1:0]  hold_data_s [POS_COUNT];

  lane_buffer #(
    .POS_COUNT  (POS_COUNT),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load_s),
    .clear     (hold_clear_s),
    .load_data (in_pixel),
    .lanes     (hold_data_s),
    .full      (hold_full_s)
  );

  assign in_ready = !hold_full_s;
`else
  assign in_ready = !active_full_s;
`endif

  lane_buffer #(
    .POS_COUNT  (POS_COUNT),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_active (
    .clk       (clk),
    .rst       (rst),
    .load      (active_load_s),
    .clear     (active_clear_s),
    .load_data (active_load_data_s),
    .lanes     (active_data_s),
    .full      (active_full_s)
  );

  // Handshake decode and buffer load/clear steering
  always_comb begin
    accept_s       = in_valid && in_ready;
    xfer_s         = out_valid_r && out_ready;
    last_lane_s    = (index_r == LANE_BITS'(POS_COUNT - 1));
    drain_s        = xfer_s && last_lane_s;
    lane_next_s    = index_r + LANE_BITS'(1);
    x_wrap_s       = (x_r == WIDTH_BITS'(WIDTH - 1));
    y_wrap_s       = (y_r == HEIGHT_BITS'(HEIGHT - 1));
    active_clear_s = drain_s;
`ifdef PIXEL_SERIALIZER_SKID_EN
    // A beat arriving just as an unbacked active buffer drains goes straight in, avoiding a bubble
    refill_hold_s  = drain_s && hold_full_s;
    refill_in_s    = drain_s && !hold_full_s && accept_s;
    active_load_s  = (accept_s && (state_r == EMPTY)) || refill_hold_s || refill_in_s;
    hold_load_s    = accept_s && (state_r == SHIFT) && !refill_in_s;
    hold_clear_s   = refill_hold_s;
    for (int i = 0; i < POS_COUNT; i++) begin
      if (refill_hold_s) begin
        active_load_data_s[i] = hold_data_s[i];
      end else begin
        active_load_data_s[i] = in_pixel[i];
      end
    end
`else
    refill_hold_s  = 1'b0;
    refill_in_s    = 1'b0;
    active_load_s  = accept_s;
    for (int i = 0; i < POS_COUNT; i++) begin
      active_load_data_s[i] = in_pixel[i];
    end
`endif
  end

  // EMPTY/SHIFT sequencing, registered pixel outputs and the inline raster coordinate counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= EMPTY;
      index_r      <= '0;
      x_r          <= '0;
      y_r          <= '0;
      addr_r       <= '0;
      out_valid_r  <= 1'b0;
      out_pixel_r  <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r     <= SHIFT;
            out_valid_r <= 1'b1;
            out_pixel_r <= in_pixel[0];
            index_r     <= '0;
          end
        end
        SHIFT: begin
          if (xfer_s) begin
            frame_done_r <= x_wrap_s && y_wrap_s;
            if (x_wrap_s) begin
              x_r <= '0;
              if (y_wrap_s) begin
                y_r    <= '0;
                addr_r <= '0;
              end else begin
                y_r    <= y_r + HEIGHT_BITS'(1);
                addr_r <= addr_r + ADDR_BITS'(1);
              end
            end else begin
              x_r    <= x_r + WIDTH_BITS'(1);
              addr_r <= addr_r + ADDR_BITS'(1);
            end

            if (!last_lane_s) begin
              index_r     <= lane_next_s;
              out_pixel_r <= active_data_s[lane_next_s];
            end else if (refill_hold_s) begin
              index_r     <= '0;
`ifdef PIXEL_SERIALIZER_SKID_EN
              out_pixel_r <= hold_data_s[0];
`else
              out_pixel_r <= in_pixel[0];
`endif
            end else if (refill_in_s) begin
              index_r     <= '0;
              out_pixel_r <= in_pixel[0];
            end else begin
              index_r     <= '0;
              state_r     <= EMPTY;
              out_valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= EMPTY;
          index_r     <= '0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_r;
  assign out_pixel  = out_pixel_r;
  assign out_x      = x_r;
  assign out_y      = y_r;
  assign out_addr   = addr_r;
  assign frame_done = frame_done_r;
  assign out_last   = out_valid_r && x_wrap_s && y_wrap_s;

endmodule

// File: tb/tb_pixel_serializer.sv
// Self-checking bench for pixel_serializer: a queue/arithmetic raster model checked every cycle,
// plus directed scenarios with literal expectations. Skid scenarios run when PIXEL_SERIALIZER_SKID_EN is defined.
module tb_pixel_serializer;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int P  = 4;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [PB-1:0] in_pixel [P];
  logic          in_ready;
  logic          out_valid;
  logic [PB-1:0] out_pixel;
  logic [2:0]    out_x;
  logic [0:0]    out_y;
  logic [3:0]    out_addr;
  logic          out_last;
  logic          frame_done;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [PB-1:0] exp_q [$];
  int            n_xfer = 0;
  logic          fd_exp = 1'b0;
  bit            t3_done = 1'b0;

  pixel_serializer #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .POS_COUNT  (P),
    .PIXEL_BITS (PB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one beat (lanes base..base+3) and hold it until accepted
  task automatic send_beat(input logic [PB-1:0] base);
    int guard;
    guard = 0;
    for (int i = 0; i < P; i++) in_pixel[i] = base + PB'(i);
    in_valid = 1'b1;
    while (!in_ready && guard < 300) begin
      step();
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_beat_timeout: in_ready still 0 after %0d cycles", guard);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (out_valid && guard < 300) begin
      step();
      guard++;
    end
    step();
    chk("drain_out_valid", out_valid, 1'b0);
  endtask

  // Reference model: queue of accepted lanes in order, coordinates derived from the transfer count
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      n_xfer = 0;
      fd_exp = 1'b0;
    end else begin
      chk("frame_done", frame_done, fd_exp);
      chk("out_valid", out_valid, exp_q.size() != 0);
`ifdef PIXEL_SERIALIZER_SKID_EN
      chk("in_ready", in_ready, exp_q.size() <= P);
`else
      chk("in_ready", in_ready, exp_q.size() == 0);
`endif
      fd_exp = 1'b0;
      if (out_valid && exp_q.size() != 0) begin
        chk("pixel", out_pixel, exp_q[0]);
        chk("x", out_x, n_xfer % W);
        chk("y", out_y, (n_xfer / W) % H);
        chk("addr", out_addr, n_xfer % (W * H));
        chk("last", out_last, (n_xfer % (W * H)) == (W * H - 1));
        if (out_ready) begin
          void'(exp_q.pop_front());
          fd_exp = ((n_xfer % (W * H)) == (W * H - 1));
          n_xfer++;
        end
      end else begin
        chk("last_idle", out_last, 1'b0);
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < P; i++) exp_q.push_back(in_pixel[i]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int x8;
    int y8;
    int last_addr;
    int fd_pulses;
    for (int i = 0; i < P; i++) in_pixel[i] = '0;

    // Reset values
    apply_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_pixel", out_pixel, 8'd0);
    chk("rst_out_x", out_x, 3'd0);
    chk("rst_out_y", out_y, 1'd0);
    chk("rst_out_addr", out_addr, 4'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);

    // 1: single beat {10,11,12,13}
    out_ready = 1'b1;
    send_beat(8'd10);
    for (int i = 0; i < P; i++) begin
      chk("t1_pixel", out_pixel, 10 + i);
      chk("t1_x", out_x, i);
      chk("t1_addr", out_addr, i);
`ifndef PIXEL_SERIALIZER_SKID_EN
      chk("t1_in_ready", in_ready, 1'b0);
`endif
      step();
    end
    chk("t1_idle", out_valid, 1'b0);
    chk("t1_ready_back", in_ready, 1'b1);

    // 2: a full frame of 0x00..0x0F
    apply_reset();
    out_ready = 1'b1;
    x8 = -1;
    y8 = -1;
    last_addr = -1;
    fd_pulses = 0;
    fork
      begin
        for (int b = 0; b < 4; b++) send_beat(PB'(4 * b));
      end
      begin
        repeat (30) begin
          if (out_valid && out_addr == 4'd8) begin
            x8 = out_x;
            y8 = out_y;
          end
          if (out_last) last_addr = out_addr;
          if (frame_done) fd_pulses++;
          step();
        end
      end
    join
    chk("t2_x_at8", x8, 0);
    chk("t2_y_at8", y8, 1);
    chk("t2_last_addr", last_addr, 15);
    chk("t2_fd_pulses", fd_pulses, 1);
    send_beat(8'h20);
    chk("t2_next_addr", out_addr, 4'd0);
    chk("t2_next_x", out_x, 3'd0);
    chk("t2_next_y", out_y, 1'd0);
    chk("t2_next_pixel", out_pixel, 8'h20);
    drain();

    // 3: pseudo-random out_ready over two frames
    t3_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send_beat(8'h40 + PB'(4 * k));
        t3_done = 1'b1;
      end
      begin
        guard = 0;
        while (!t3_done && guard < 600) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
          guard++;
        end
      end
    join
    drain();

    // 4: reset while lane 2 (addr 6) is presented
    apply_reset();
    out_ready = 1'b1;
    send_beat(8'h30);
    send_beat(8'h34);
    guard = 0;
    while (!(out_valid && out_addr == 4'd6) && guard < 100) begin
      step();
      guard++;
    end
    chk("t4_reach_addr6", out_addr, 4'd6);
    chk("t4_lane2_pixel", out_pixel, 8'h36);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_out_valid", out_valid, 1'b0);
    chk("t4_in_ready", in_ready, 1'b1);
    chk("t4_addr", out_addr, 4'd0);
    chk("t4_x", out_x, 3'd0);
    chk("t4_y", out_y, 1'd0);
    send_beat(8'h50);
    chk("t4_restart_addr", out_addr, 4'd0);
    chk("t4_restart_pixel", out_pixel, 8'h50);
    drain();

`ifdef PIXEL_SERIALIZER_SKID_EN
    // 5: continuous input, no bubble
    apply_reset();
    out_ready = 1'b1;
    send_beat(8'h00);
    fork
      begin
        for (int b = 1; b < 5; b++) send_beat(PB'(4 * b));
      end
      begin
        for (int i = 0; i < 16; i++) begin
          chk("t5_valid", out_valid, 1'b1);
          chk("t5_addr", out_addr, i);
          step();
        end
      end
    join
    drain();

    // 6: both buffers fill under backpressure
    apply_reset();
    out_ready = 1'b0;
    send_beat(8'h60);
    send_beat(8'h64);
    chk("t6_in_ready", in_ready, 1'b0);
    chk("t6_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t6_pixel", out_pixel, 8'h60 + i);
      step();
    end
    chk("t6_idle", out_valid, 1'b0);
`endif

    step();
    chk("model_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
